// File: rtl/famicom_cpu_bus_driver_pkg.sv
// Shared constants and types for the Famicom CPU bus initiator and its helpers.
// Also holds the reset-vector address that the bus presents between commands.
package famicom_cpu_bus_driver_pkg;

  typedef enum logic {
    PH_LOW  = 1'b0,
    PH_HIGH = 1'b1
  } phase_e;

  typedef enum logic [1:0] {
    CYC_IDLE  = 2'd0,
    CYC_READ  = 2'd1,
    CYC_WRITE = 2'd2
  } cyc_kind_e;

  localparam logic [15:0] RESET_VECTOR_ADDR = 16'hFFFC;
  localparam logic [15:0] IDLE_ADDR_DEFAULT = RESET_VECTOR_ADDR;

endpackage

// File: rtl/famicom_sync2.sv
// Two-flop synchronizer for asynchronous cartridge/PPU-side level inputs.
module famicom_sync2 (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/famicom_cpu_bus_driver.sv
// Host-side Famicom CPU bus initiator: free-running m2 with one bus cycle per
// m2 period, each owned by a latched command or by an idle read of IDLE_ADDR.
module famicom_cpu_bus_driver
  import famicom_cpu_bus_driver_pkg::*;
#(
  parameter int          M2_LOW_CLKS  = 6,
  parameter int          M2_HIGH_CLKS = 6,
  parameter int          WR_HOLD_CLKS = 1,
  parameter logic [15:0] IDLE_ADDR    = IDLE_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rw,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        m2,
  output logic        romsel,
  output logic        cpu_rw,
  output logic [14:0] cpu_addr,
  output logic [7:0]  cpu_data_out,
  output logic        cpu_data_oe,
  input  logic [7:0]  cpu_data_in,
  input  logic        irq_n,
  output logic        irq_active,
  output logic [31:0] m2_count
);

  localparam int MAX_CLKS = (M2_LOW_CLKS > M2_HIGH_CLKS) ? M2_LOW_CLKS : M2_HIGH_CLKS;
  localparam int CW       = $clog2(MAX_CLKS);

  localparam logic [CW-1:0] LOW_LAST  = CW'(M2_LOW_CLKS - 1);
  localparam logic [CW-1:0] HIGH_LAST = CW'(M2_HIGH_CLKS - 1);
  localparam logic [CW-1:0] HIGH_PRE  = CW'(M2_HIGH_CLKS - 2);
  localparam logic [CW-1:0] HOLD_LAST = CW'(WR_HOLD_CLKS - 1);

  phase_e          phase_q;
  logic [CW-1:0]   cnt_q;
  cyc_kind_e       kind_q;
  logic [15:0]     addr_q;
  logic [7:0]      wdata_q;
  logic            hold_q;
  logic            oe_arm_q;
  logic            a15_q;
  logic            m2_q;
  logic            romsel_q;
  logic            cpu_rw_q;
  logic [14:0]     cpu_addr_q;
  logic [7:0]      cpu_data_out_q;
  logic            cpu_data_oe_q;
  logic            cmd_ready_q;
  logic            rsp_valid_q;
  logic [7:0]      rsp_rdata_q;
  logic [31:0]     m2_count_q;

  logic            end_high;
  logic            end_low;
  logic            accept;
  logic            hold_start;
  logic            apply_now;
  cyc_kind_e       kind_d;
  logic [15:0]     addr_d;
  logic [7:0]      wdata_d;
  cyc_kind_e       app_kind;
  logic [15:0]     app_addr;
  logic [7:0]      app_wdata;

  always_comb begin
    end_high   = (phase_q == PH_HIGH) && (cnt_q == HIGH_LAST);
    end_low    = (phase_q == PH_LOW) && (cnt_q == LOW_LAST);
    accept     = cmd_valid && cmd_ready_q;
    kind_d     = CYC_IDLE;
    addr_d     = IDLE_ADDR;
    wdata_d    = wdata_q;
    if (accept) begin
      kind_d  = cmd_rw ? CYC_READ : CYC_WRITE;
      addr_d  = cmd_addr;
      wdata_d = cmd_wdata;
    end
    // A finishing write keeps its bus image for WR_HOLD_CLKS before the next cycle takes over.
    hold_start = end_high && (kind_q == CYC_WRITE) && (WR_HOLD_CLKS > 0);
    apply_now  = (end_high && !hold_start) ||
                 (hold_q && (phase_q == PH_LOW) && (cnt_q == HOLD_LAST));
    app_kind   = end_high ? kind_d  : kind_q;
    app_addr   = end_high ? addr_d  : addr_q;
    app_wdata  = end_high ? wdata_d : wdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q        <= PH_LOW;
      cnt_q          <= '0;
      kind_q         <= CYC_IDLE;
      addr_q         <= IDLE_ADDR;
      wdata_q        <= 8'h00;
      hold_q         <= 1'b0;
      oe_arm_q       <= 1'b0;
      a15_q          <= IDLE_ADDR[15];
      m2_q           <= 1'b0;
      romsel_q       <= 1'b1;
      cpu_rw_q       <= 1'b1;
      cpu_addr_q     <= IDLE_ADDR[14:0];
      cpu_data_out_q <= 8'h00;
      cpu_data_oe_q  <= 1'b0;
      cmd_ready_q    <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_rdata_q    <= 8'h00;
      m2_count_q     <= 32'd0;
    end else begin
      rsp_valid_q <= 1'b0;
      cmd_ready_q <= (phase_q == PH_HIGH) && (cnt_q == HIGH_PRE);

      if (end_high) begin
        phase_q    <= PH_LOW;
        cnt_q      <= '0;
        m2_q       <= 1'b0;
        romsel_q   <= 1'b1;
        m2_count_q <= m2_count_q + 32'd1;
        kind_q     <= kind_d;
        addr_q     <= addr_d;
        wdata_q    <= wdata_d;
        hold_q     <= hold_start;
        if (kind_q == CYC_READ) begin
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= cpu_data_in;
        end
      end else if (end_low) begin
        phase_q  <= PH_HIGH;
        cnt_q    <= '0;
        m2_q     <= 1'b1;
        romsel_q <= ~a15_q;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end

      if (oe_arm_q) begin
        cpu_data_oe_q <= 1'b1;
        oe_arm_q      <= 1'b0;
      end

      if (apply_now) begin
        cpu_addr_q    <= app_addr[14:0];
        a15_q         <= app_addr[15];
        cpu_rw_q      <= (app_kind != CYC_WRITE);
        cpu_data_oe_q <= 1'b0;
        oe_arm_q      <= (app_kind == CYC_WRITE);
        hold_q        <= 1'b0;
        if (app_kind == CYC_WRITE) begin
          cpu_data_out_q <= app_wdata;
        end
      end
    end
  end

  famicom_sync2 u_irq_sync (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .d_i     (~irq_n),
    .q_o     (irq_active)
  );

  assign cmd_ready    = cmd_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign m2           = m2_q;
  assign romsel       = romsel_q;
  assign cpu_rw       = cpu_rw_q;
  assign cpu_addr     = cpu_addr_q;
  assign cpu_data_out = cpu_data_out_q;
  assign cpu_data_oe  = cpu_data_oe_q;
  assign m2_count     = m2_count_q;

endmodule

// File: tb/tb_famicom_cpu_bus_driver.sv
// Self-checking bench: period-arithmetic bus model compared every clk, plus directed literals.
module tb_famicom_cpu_bus_driver;

  localparam int L = 6;
  localparam int H = 6;
  localparam int W = 1;
  localparam int P = L + H;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_rw = 1'b1;
  logic [15:0] cmd_addr = 16'h0000;
  logic [7:0]  cmd_wdata = 8'h00;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        m2;
  logic        romsel;
  logic        cpu_rw;
  logic [14:0] cpu_addr;
  logic [7:0]  cpu_data_out;
  logic        cpu_data_oe;
  logic [7:0]  cpu_data_in;
  logic        irq_n = 1'b1;
  logic        irq_active;
  logic [31:0] m2_count;

  int checks = 0;
  int failures = 0;
  int rsp_pulses = 0;
  int handshakes = 0;

  always #5 clk = ~clk;

  famicom_cpu_bus_driver dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .m2(m2), .romsel(romsel), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr),
    .cpu_data_out(cpu_data_out), .cpu_data_oe(cpu_data_oe),
    .cpu_data_in(cpu_data_in), .irq_n(irq_n), .irq_active(irq_active),
    .m2_count(m2_count)
  );

  function automatic logic [7:0] cart_fn(input logic [14:0] a);
    return (a == 15'h0000) ? 8'hA5 : (a[7:0] ^ {1'b0, a[14:8]});
  endfunction

  // Cartridge answers only while the host reads during m2 high.
  assign cpu_data_in = (cpu_rw && m2) ? cart_fn(cpu_addr) : 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: bus cycle ownership per m2 period; index k+1 holds period k, index 0 is "before reset".
  int          t;
  int          kind_m [0:255];
  logic [15:0] addr_m [0:255];
  logic [7:0]  data_m [0:255];
  logic [7:0]  exp_rdata;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t = 0;
      exp_rdata = 8'h00;
      for (int i = 0; i < 2; i++) begin
        kind_m[i] = 0;
        addr_m[i] = 16'hFFFC;
        data_m[i] = 8'h00;
      end
    end else begin
      if ((t % P) == P - 1) begin
        if (kind_m[t / P + 1] == 1) exp_rdata = cart_fn(addr_m[t / P + 1][14:0]);
        if (cmd_valid) begin
          kind_m[t / P + 2] = cmd_rw ? 1 : 2;
          addr_m[t / P + 2] = cmd_addr;
          data_m[t / P + 2] = cmd_wdata;
        end else begin
          kind_m[t / P + 2] = 0;
          addr_m[t / P + 2] = 16'hFFFC;
          data_m[t / P + 2] = data_m[t / P + 1];
        end
      end
      t = t + 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      int k, p, c, pv, start, src;
      logic exp_m2, exp_oe;
      logic [7:0] exp_dout;
      k = t / P;
      p = t % P;
      c = k + 1;
      pv = k;
      start = (kind_m[pv] == 2 && W > 0) ? W : 0;
      src = (p >= start) ? c : pv;
      exp_m2 = (p >= L);
      exp_oe = (kind_m[c] == 2 && p >= start + 1) || (kind_m[pv] == 2 && p < W);
      exp_dout = (kind_m[pv] == 2 && p < W) ? data_m[pv] : data_m[c];
      chk("m2", m2, exp_m2);
      chk("romsel", romsel, !(exp_m2 && addr_m[c][15]));
      chk("cpu_addr", cpu_addr, addr_m[src][14:0]);
      chk("cpu_rw", cpu_rw, kind_m[src] != 2);
      chk("cpu_data_oe", cpu_data_oe, exp_oe);
      if (exp_oe) chk("cpu_data_out", cpu_data_out, exp_dout);
      chk("cmd_ready", cmd_ready, p == P - 1);
      chk("rsp_valid", rsp_valid, (p == 0) && (kind_m[pv] == 1));
      chk("rsp_rdata", rsp_rdata, exp_rdata);
      chk("m2_count", m2_count, k);
      if (rsp_valid) rsp_pulses++;
      if (cmd_valid && cmd_ready) handshakes++;
    end
  end

  task automatic send(input logic rw, input logic [15:0] addr, input logic [7:0] data);
    bit done = 0;
    cmd_valid = 1'b1;
    cmd_rw = rw;
    cmd_addr = addr;
    cmd_wdata = data;
    for (int i = 0; i < 3 * P && !done; i++) begin
      if (cmd_ready) done = 1;
      @(negedge clk);
    end
    if (!done) begin
      failures++;
      $display("FAIL send_timeout: addr %0h not accepted", addr);
    end
  endtask

  initial begin
    // Reset values while held in reset.
    repeat (2) @(negedge clk);
    chk("rst_m2", m2, 0);
    chk("rst_romsel", romsel, 1);
    chk("rst_addr", cpu_addr, 15'h7FFC);
    chk("rst_dout", cpu_data_out, 8'h00);
    chk("rst_rdata", rsp_rdata, 8'h00);
    #2 rst_n = 1'b1;

    // Idle running: 10 full periods.
    repeat (10 * P) @(negedge clk);
    chk("idle_m2_count", m2_count, 32'd10);
    chk("idle_no_rsp", rsp_pulses, 0);

    // Read $8000.
    send(1'b1, 16'h8000, 8'h00);
    cmd_valid = 1'b0;
    repeat (L) @(negedge clk);
    chk("rd_romsel_high", romsel, 0);
    chk("rd_addr", cpu_addr, 15'h0000);
    chk("rd_rw", cpu_rw, 1);
    repeat (H) @(negedge clk);
    chk("rd_rsp_valid", rsp_valid, 1);
    chk("rd_rsp_data", rsp_rdata, 8'hA5);
    @(negedge clk);
    chk("rd_rsp_pulse_end", rsp_valid, 0);

    // Write $6000 <- $3C.
    send(1'b0, 16'h6000, 8'h3C);
    cmd_valid = 1'b0;
    chk("wr_oe_clk0", cpu_data_oe, 0);
    @(negedge clk);
    chk("wr_oe_clk1", cpu_data_oe, 1);
    chk("wr_rw", cpu_rw, 0);
    chk("wr_addr", cpu_addr, 15'h6000);
    repeat (P - 2) @(negedge clk);
    chk("wr_m2_last", m2, 1);
    chk("wr_romsel", romsel, 1);
    chk("wr_data", cpu_data_out, 8'h3C);
    @(negedge clk);
    chk("wr_oe_hold", cpu_data_oe, 1);
    @(negedge clk);
    chk("wr_oe_drop", cpu_data_oe, 0);

    // Back-to-back: two writes then a read with cmd_valid held.
    rsp_pulses = 0;
    handshakes = 0;
    send(1'b0, 16'h8000, 8'h80);
    send(1'b0, 16'hA001, 8'h01);
    send(1'b1, 16'hC000, 8'h00);
    cmd_valid = 1'b0;
    repeat (2 * P) @(negedge clk);
    chk("b2b_handshakes", handshakes, 3);
    chk("b2b_responses", rsp_pulses, 1);

    // IRQ synchronizer latency.
    #2 irq_n = 1'b0;
    @(posedge clk); #1 chk("irq_lat1", irq_active, 0);
    @(posedge clk); #1 chk("irq_lat2", irq_active, 1);
    #2 irq_n = 1'b1;
    @(posedge clk); #1 chk("irq_clr1", irq_active, 1);
    @(posedge clk); #1 chk("irq_clr2", irq_active, 0);

    // Reset asserted mid-HIGH of a read.
    @(negedge clk);
    send(1'b1, 16'h8000, 8'h00);
    cmd_valid = 1'b0;
    repeat (L + 2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_m2", m2, 0);
    chk("mid_rst_romsel", romsel, 1);
    chk("mid_rst_count", m2_count, 0);
    repeat (2) @(negedge clk);
    chk("mid_rst_no_rsp", rsp_valid, 0);
    #2 rst_n = 1'b1;
    repeat (L) @(negedge clk);
    chk("post_rst_idle_addr", cpu_addr, 15'h7FFC);
    chk("post_rst_romsel", romsel, 0);
    repeat (H - 1) @(negedge clk);
    chk("post_rst_ready", cmd_ready, 1);
    repeat (P + 1) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
